// File: rtl/mips_multicycle_ctrl.sv
// Moore main control FSM for the multicycle MIPS datapath (fetch/decode/execute/mem/writeback).
// Optional addi support is enabled by defining MC_CTRL_ADDI_EN.
module mips_multicycle_ctrl (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] Opcode,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       pc_en,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALU_op,
  output logic [1:0] PCSource,
  output logic       illegal_op,
  output logic [3:0] state
);

  localparam int unsigned OP_W = 6;
  localparam logic [OP_W-1:0] OP_R    = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW   = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW   = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ  = 6'b000100;
  localparam logic [OP_W-1:0] OP_J    = 6'b000010;
`ifdef MC_CTRL_ADDI_EN
  localparam logic [OP_W-1:0] OP_ADDI = 6'b001000;
`endif

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_IDLE   = 4'd15
  } state_t;

  state_t state_q, state_d;

  // State register; reset parks the FSM in IDLE so every output drops at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state and Moore output decode; only illegal_op looks at Opcode directly.
  always_comb begin
    state_d     = state_q;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALU_op      = 2'b00;
    PCSource    = 2'b00;
    illegal_op  = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        MemRead = 1'b1;
        IRWrite = 1'b1;
        PCWrite = 1'b1;
        ALUSrcB = 2'b01;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        // Branch target is precomputed here while the opcode is decoded.
        ALUSrcB = 2'b11;
        case (Opcode)
          OP_R:          state_d = S_EXEC;
          OP_LW, OP_SW:  state_d = S_MEMADR;
          OP_BEQ:        state_d = S_BRANCH;
          OP_J:          state_d = S_JUMP;
`ifdef MC_CTRL_ADDI_EN
          OP_ADDI:       state_d = S_ADDIEX;
`endif
          default: begin
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        state_d  = S_FETCH;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALU_op  = 2'b10;
        state_d = S_RWB;
      end
      S_RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALU_op      = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        state_d  = S_FETCH;
      end
`ifdef MC_CTRL_ADDI_EN
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
`endif
      default: state_d = S_FETCH;
    endcase
  end

  assign pc_en = PCWrite | (PCWriteCond & Zero);
  assign state = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized self-checking bench for mips_multicycle_ctrl against an instruction-level reference model.
// Honors MC_CTRL_ADDI_EN the same way as the design.
module tb_mips_multicycle_ctrl;

  logic       clk;
  logic       reset_n;
  logic [5:0] Opcode;
  logic       Zero;
  logic       PCWrite, PCWriteCond, pc_en, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, illegal_op;
  logic [1:0] ALUSrcB, ALU_op, PCSource;
  logic [3:0] state;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  mips_multicycle_ctrl dut (
    .clk(clk), .reset_n(reset_n), .Opcode(Opcode), .Zero(Zero),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .pc_en(pc_en), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg),
    .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALU_op(ALU_op), .PCSource(PCSource), .illegal_op(illegal_op), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,RegWrite,ALUSrcA,ALUSrcB,ALU_op,PCSource}
  logic [15:0] act_ctrl;
  assign act_ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                     RegDst, RegWrite, ALUSrcA, ALUSrcB, ALU_op, PCSource};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit addi_en();
`ifdef MC_CTRL_ADDI_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Control table straight from the per-state output list.
  function automatic logic [15:0] exp_ctrl(input int s);
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca;
    logic [1:0] srcb, aop, psrc;
    {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca} = '0;
    srcb = 2'b00; aop = 2'b00; psrc = 2'b00;
    case (s)
      0:  begin mrd = 1; irw = 1; pcw = 1; srcb = 2'b01; end
      1:  srcb = 2'b11;
      2:  begin srca = 1; srcb = 2'b10; end
      3:  begin mrd = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mwr = 1; iord = 1; end
      6:  begin srca = 1; aop = 2'b10; end
      7:  begin rw = 1; rdst = 1; end
      8:  begin srca = 1; aop = 2'b01; pcwc = 1; psrc = 2'b01; end
      9:  begin pcw = 1; psrc = 2'b10; end
      10: begin srca = 1; srcb = 2'b10; end
      11: rw = 1;
      default: ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, aop, psrc};
  endfunction

  // Instruction-level model: the state walk of one instruction, starting at FETCH.
  function automatic void instr_states(input logic [5:0] op, output int q[$], output bit illegal);
    q = '{0, 1};
    illegal = 1'b0;
    case (op)
      6'b000000: q = '{0, 1, 6, 7};
      6'b100011: q = '{0, 1, 2, 3, 4};
      6'b101011: q = '{0, 1, 2, 5};
      6'b000100: q = '{0, 1, 8};
      6'b000010: q = '{0, 1, 9};
      6'b001000: if (addi_en()) q = '{0, 1, 10, 11}; else illegal = 1'b1;
      default:   illegal = 1'b1;
    endcase
  endfunction

  // One clock: real opcode only where the FSM may look at it, garbage elsewhere.
  task automatic step(input int exp_st, input logic [5:0] op, input bit illegal);
    logic [15:0] ec;
    @(posedge clk);
    #1;
    Opcode = (exp_st == 1 || exp_st == 2) ? op : 6'($urandom);
    Zero   = 1'($urandom);
    #1;
    ec = exp_ctrl(exp_st);
    check("state", 32'(state), 32'(exp_st));
    check("ctrl", 32'(act_ctrl), 32'(ec));
    check("pc_en", 32'(pc_en), 32'(ec[15] | (ec[14] & Zero)));
    check("illegal_op", 32'(illegal_op), 32'((exp_st == 1) && illegal));
    check("mem_excl", 32'(MemRead & MemWrite), 32'(0));
    check("wr_excl", 32'(RegWrite & PCWrite), 32'(0));
  endtask

  task automatic run_instr(input logic [5:0] op);
    int q[$];
    bit ill;
    instr_states(op, q, ill);
    foreach (q[i]) step(q[i], op, ill);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_state"}, 32'(state), 32'd15);
    check({tag, "_ctrl"}, 32'(act_ctrl), 32'd0);
    check({tag, "_pc_en"}, 32'(pc_en), 32'd0);
    check({tag, "_illegal"}, 32'(illegal_op), 32'd0);
  endtask

  initial begin
    logic [5:0] op;
    logic [5:0] dir_ops[8];
    logic [5:0] pool[6];
    dir_ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000100,
                6'b000010, 6'b111111, 6'b001000};
    pool    = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
    reset_n = 1'b0;
    Opcode  = 6'b000000;
    Zero    = 1'b1;

    // Reset held for three cycles with changing inputs.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      Opcode = 6'($urandom);
      Zero   = 1'b1;
      #1;
      check_idle("reset");
    end
    @(negedge clk);
    reset_n = 1'b1;

    foreach (dir_ops[i]) run_instr(dir_ops[i]);

    // Random instruction stream, about one in six being an arbitrary opcode.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(5) == 0) op = 6'($urandom);
      else                        op = pool[$urandom_range(5)];
      run_instr(op);
    end

    // Abort a store while MemWrite is high; it must drop without a clock edge.
    step(0, 6'b101011, 1'b0);
    step(1, 6'b101011, 1'b0);
    step(2, 6'b101011, 1'b0);
    step(5, 6'b101011, 1'b0);
    check("memwr_before_abort", 32'(MemWrite), 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    check_idle("abort");
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #2;
      check_idle("abort_hold");
    end
    @(negedge clk);
    reset_n = 1'b1;

    for (int n = 0; n < 40; n++) run_instr(pool[$urandom_range(5)]);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Moore-style main control FSM for the multicycle MIPS datapath.
- Sequences instruction fetch, decode, execute, memory and writeback for R-type, lw, sw, beq and j.
- Drives the datapath mux selects and write enables.
- Drives the 2-bit ALU_op consumed by ALU_Control, which combines it with the instruction funct field to produce ALU_Ctl.

Parameters:
- None. Opcodes are fixed: R=000000, lw=100011, sw=101011, beq=000100, j=000010, addi=001000.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- Opcode  in  6  IR[31:26]; held stable by the IR register from DECODE onward.
- Zero  in  1  ALU zero flag.
- PCWrite  out  1  unconditional PC write.
- PCWriteCond  out  1  conditional PC write (beq).
- pc_en  out  1  PCWrite | (PCWriteCond & Zero); combinational.
- IorD  out  1  memory address select: 0=PC, 1=ALUOut.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  instruction register load.
- MemtoReg  out  1  register write data select: 0=ALUOut, 1=MDR.
- RegDst  out  1  destination register select: 0=rt, 1=rd.
- RegWrite  out  1  register file write enable.
- ALUSrcA  out  1  ALU A input select: 0=PC, 1=A.
- ALUSrcB  out  2  ALU B input select: 00=B, 01=4, 10=signext imm, 11=signext imm<<2.
- ALU_op  out  2  to ALU_Control: 00=add, 01=sub, 10=use funct.
- PCSource  out  2  PC source select: 00=ALU result, 01=ALUOut, 10=jump target.
- illegal_op  out  1  one-cycle pulse on unsupported opcode.
- state  out  4  current state, for debug.

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11, IDLE=15.
- reset_n low: state forced to IDLE immediately (asynchronous). All outputs are 0 in IDLE, including pc_en and illegal_op.
- IDLE -> FETCH on the first rising edge after reset_n goes high.
- Reset asserted mid-instruction: the instruction is abandoned. No further writes occur and outputs go to 0 within the same cycle.
- Transitions:
  - FETCH -> DECODE.
  - DECODE -> MEMADR on lw or sw.
  - DECODE -> EXEC on R-type.
  - DECODE -> BRANCH on beq.
  - DECODE -> JUMP on j.
  - DECODE -> ADDIEX on addi (only when the macro is defined).
  - DECODE -> FETCH on any other opcode, with illegal_op=1 during that DECODE cycle.
  - MEMADR -> MEMRD on lw, MEMWR on sw.
  - MEMRD -> MEMWB -> FETCH.
  - MEMWR -> FETCH.
  - EXEC -> RWB -> FETCH.
  - BRANCH -> FETCH.
  - JUMP -> FETCH.
  - ADDIEX -> ADDIWB -> FETCH.
  - Unused encodings (12-14) -> FETCH.
- Outputs decode combinationally from state only. Any output not listed for a state is 0.
  - FETCH: MemRead, IRWrite, PCWrite=1; ALUSrcB=01; ALU_op=00; PCSource=00; IorD=0.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALU_op=00 (branch target precompute).
  - MEMADR: ALUSrcA=1, ALUSrcB=10, ALU_op=00.
  - MEMRD: MemRead=1, IorD=1.
  - MEMWB: RegWrite=1, MemtoReg=1, RegDst=0.
  - MEMWR: MemWrite=1, IorD=1.
  - EXEC: ALUSrcA=1, ALUSrcB=00, ALU_op=10.
  - RWB: RegWrite=1, RegDst=1, MemtoReg=0.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALU_op=01, PCWriteCond=1, PCSource=01.
  - JUMP: PCWrite=1, PCSource=10.
  - ADDIEX: ALUSrcA=1, ALUSrcB=10, ALU_op=00.
  - ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0.
- Cycle counts from FETCH to the next FETCH:
  - lw: 5 cycles.
  - sw: 4 cycles.
  - R-type: 4 cycles.
  - beq: 3 cycles.
  - j: 3 cycles.
  - addi: 4 cycles.
  - illegal opcode: 2 cycles.
- Opcode is sampled only in DECODE and MEMADR. Changes in Opcode at any other time have no effect.
- MemRead and MemWrite are never both 1. RegWrite and PCWrite are never both 1.

Optional Feature:
- Macro: MC_CTRL_ADDI_EN.
- Defined: opcode 001000 follows DECODE -> ADDIEX -> ADDIWB -> FETCH.
- Undefined: opcode 001000 is treated as illegal (illegal_op pulse, DECODE -> FETCH), and states ADDIEX and ADDIWB are unreachable.

Test Plan:
- Reset held low 3 cycles, then released -> all outputs 0 with state=15 while reset_n is low; state=0 and MemRead=IRWrite=PCWrite=1 one edge after release.
- Opcode=000000 -> state sequence 0,1,6,7,0; ALU_op=10 in EXEC; RegWrite=RegDst=1 in RWB.
- Opcode=100011 -> state sequence 0,1,2,3,4,0; IorD=1 and MemRead=1 in MEMRD; MemtoReg=RegWrite=1 in MEMWB. Opcode=101011 -> sequence 0,1,2,5,0 with MemWrite=1 only in state 5.
- Opcode=000100 with Zero=1 -> pc_en=1, ALU_op=01, PCSource=01 in BRANCH. Same with Zero=0 -> pc_en=0. Both return to FETCH next cycle.
- Opcode=111111 -> illegal_op=1 for exactly one cycle (state=1), then state=0. Opcode=001000 gives sequence 0,1,10,11,0 with the macro defined, and an illegal_op pulse without it.
- reset_n pulled low while in MEMWR (sw) -> MemWrite drops to 0 in the same cycle without waiting for a clock edge; after release the FSM restarts at IDLE then FETCH.
